// File: rtl/ms_pipe_pkg.sv
// Shared helpers for the master-slave register pipeline.
package ms_pipe_pkg;

  // Value loaded into every data latch on reset.
  localparam logic DATA_RST_BIT = 1'b0;

  // Bits needed to count 0..stages valid slaves.
  function automatic int occ_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/ms_stage.sv
// One master/slave stage: master captures on posedge, slave mirrors it on negedge.
module ms_stage
  import ms_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_data,
  output logic             s_vld,
  output logic [WIDTH-1:0] s_data
);

  logic             m_vld;
  logic [WIDTH-1:0] m_data;

  // Master: flush drops the valid bit, otherwise advance when downstream has room.
  // Data only moves with a valid token so an idle stage keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld  <= 1'b0;
      m_data <= {WIDTH{DATA_RST_BIT}};
    end else if (flush) begin
      m_vld  <= 1'b0;
    end else if (adv) begin
      m_vld  <= up_vld;
      if (up_vld) m_data <= up_data;
    end
  end

  // Slave: unconditional copy of the master half a cycle later.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld  <= 1'b0;
      s_data <= {WIDTH{DATA_RST_BIT}};
    end else begin
      s_vld  <= m_vld;
      s_data <= m_data;
    end
  end

endmodule

// File: rtl/ms_pipe_reg.sv
// WIDTH-bit, STAGES-deep master-slave pipeline with valid/ready, flush and occupancy.
module ms_pipe_reg
  import ms_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int OCC_W  = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0]            s_vld;
  logic [STAGES-1:0]            ready;
  logic [STAGES-1:0][WIDTH-1:0] s_data;

  // Ready chain in closed form: stage i may advance unless every slave from i
  // to the tail is valid and the consumer is stalled (same as the serial
  // !s_vld[i] | ready[i+1] chain, without a self-referencing vector).
  always_comb begin
    logic [STAGES-1:0] below;
    ready = '0;
    for (int i = 0; i < STAGES; i++) begin
      below    = ~({STAGES{1'b1}} << i);
      ready[i] = out_ready | ~(&(s_vld | below));
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    logic             up_vld;
    logic [WIDTH-1:0] up_data;
    if (g == 0) begin : g_head
      assign up_vld  = in_valid;
      assign up_data = in_data;
    end else begin : g_body
      assign up_vld  = s_vld[g-1];
      assign up_data = s_data[g-1];
    end
    ms_stage #(.WIDTH(WIDTH)) u_stg (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .adv     (ready[g]),
      .up_vld  (up_vld),
      .up_data (up_data),
      .s_vld   (s_vld[g]),
      .s_data  (s_data[g])
    );
  end

  // Occupancy is the popcount of slave valids, so it only moves on negedge.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(s_vld[i]);
  end

  assign in_ready  = ready[0];
  assign out_valid = s_vld[STAGES-1];
  assign out_data  = s_data[STAGES-1];

endmodule

// File: tb/tb_ms_pipe_reg.sv
// Bench for ms_pipe_reg: a 3-stage and a 1-stage instance share one input stream,
// each checked against its own queue-based model.
`timescale 1ns/1ps
module tb_ms_pipe_reg;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } item_t;

  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       rdy3, ov3, rdy1, ov1;
  logic [7:0] od3, od1;
  logic [1:0] occ3;
  logic [0:0] occ1;

  int    errs = 0, checks = 0, cyc = 0;
  item_t mq [2][$];
  int    last_pop [2];
  int    ns [2] = '{3, 1};
  logic  exp_vld [2];
  logic  pv3, pv1;
  logic [7:0] pd3, pd1;

  always #5 clk = ~clk;

  ms_pipe_reg #(.WIDTH(8), .STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready), .occupancy(occ3));

  ms_pipe_reg #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .occupancy(occ1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int u);
    return (u == 0) ? rdy3 : rdy1;
  endfunction
  function automatic logic get_ov(input int u);
    return (u == 0) ? ov3 : ov1;
  endfunction
  function automatic logic [7:0] get_od(input int u);
    return (u == 0) ? od3 : od1;
  endfunction
  function automatic int get_occ(input int u);
    return (u == 0) ? int'(occ3) : int'(occ1);
  endfunction

  // Pipeline can take an item unless it already holds STAGES items and the consumer stalls.
  function automatic logic exp_rdy(input int u);
    return (mq[u].size() < ns[u]) || out_ready;
  endfunction

  // Head reaches the output STAGES-1 cycles after accept, but never before its predecessor left.
  function automatic logic m_out_vld(input int u);
    int arr;
    if (mq[u].size() == 0) return 1'b0;
    arr = mq[u][0].acc + ns[u] - 1;
    if (last_pop[u] > arr) arr = last_pop[u];
    return arr <= cyc;
  endfunction

  task automatic check_out();
    for (int u = 0; u < 2; u++) begin
      exp_vld[u] = m_out_vld(u);
      chk($sformatf("out_valid[S=%0d]", ns[u]), get_ov(u), exp_vld[u]);
      if (exp_vld[u]) chk($sformatf("out_data[S=%0d]", ns[u]), get_od(u), mq[u][0].d);
      chk($sformatf("occupancy[S=%0d]", ns[u]), get_occ(u), mq[u].size());
    end
  endtask

  // One cycle, entered and left just after a negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic fl,
                      output logic acc0);
    logic  acc [2];
    item_t it;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    #2;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("in_ready[S=%0d]", ns[u]), get_rdy(u), exp_rdy(u));
      acc[u] = v && exp_rdy(u);
    end
    acc0 = acc[0];
    @(posedge clk);
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (exp_vld[u] && ordy) begin
        void'(mq[u].pop_front());
        last_pop[u] = cyc;
      end
      if (fl) begin
        mq[u].delete();
        last_pop[u] = 0;
      end else if (acc[u]) begin
        it.d = d; it.acc = cyc;
        mq[u].push_back(it);
      end
    end
    @(negedge clk); #1;
    check_out();
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, a);
  endtask

  // Asynchronous reset, asserted between edges; outputs must clear at once.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_out_valid[S=%0d]", ns[u]), get_ov(u), 1'b0);
      chk($sformatf("rst_out_data[S=%0d]", ns[u]), get_od(u), 8'h00);
      chk($sformatf("rst_occupancy[S=%0d]", ns[u]), get_occ(u), 0);
      chk($sformatf("rst_in_ready[S=%0d]", ns[u]), get_rdy(u), 1'b1);
      mq[u].delete();
      last_pop[u] = 0;
      exp_vld[u]  = 1'b0;
    end
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Outputs may only move on negedge: compare 1 ns after every posedge.
  always @(posedge clk) begin
    if (rst_n) begin
      pv3 = ov3; pd3 = od3; pv1 = ov1; pd1 = od1;
      #1;
      if (rst_n) begin
        chk("edge_out_valid[S=3]", ov3, pv3);
        chk("edge_out_data[S=3]", od3, pd3);
        chk("edge_out_valid[S=1]", ov1, pv1);
        chk("edge_out_data[S=1]", od1, pd1);
      end
    end
  end

  initial begin
    logic a;
    int   nxt;
    exp_vld[0] = 1'b0; exp_vld[1] = 1'b0;
    last_pop[0] = 0; last_pop[1] = 0;

    // Power-up reset, then a single item.
    async_reset();
    step(1'b1, 8'h5A, 1'b1, 1'b0, a);
    chk("first_5A_S1_visible", ov1, 1'b1);
    idle(4, 1'b1);

    // Streaming with the consumer always ready.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0, a);
      if (i >= 4) chk("stream_occupancy_S3", occ3, 2'd3);
    end
    idle(4, 1'b1);

    // Back-pressure: offer 5 held items to a stalled consumer.
    nxt = 1;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'(nxt), 1'b0, 1'b0, a);
      if (a) nxt++;
    end
    chk("bp_accepted", nxt, 4);
    chk("bp_in_ready", rdy3, 1'b0);
    chk("bp_occupancy", occ3, 2'd3);
    while (nxt <= 5) begin
      step(1'b1, 8'(nxt), 1'b1, 1'b0, a);
      if (a) nxt++;
    end
    idle(5, 1'b1);

    // Full pipeline with consume and accept on the same edge.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, a);
    chk("full_in_ready_stalled", rdy3, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, a);
    chk("full_simul_accept", a, 1'b1);
    chk("full_simul_occupancy", occ3, 2'd3);
    idle(5, 1'b1);

    // Flush with two items held and a third presented.
    step(1'b1, 8'hA1, 1'b0, 1'b0, a);
    step(1'b1, 8'hA2, 1'b0, 1'b0, a);
    step(1'b1, 8'hA3, 1'b0, 1'b1, a);
    chk("flush_occupancy_S3", occ3, 2'd0);
    chk("flush_occupancy_S1", occ1, 1'd0);
    idle(4, 1'b1);

    // Reset mid-stream with items in flight, then a fresh item.
    step(1'b1, 8'hB1, 1'b0, 1'b0, a);
    step(1'b1, 8'hB2, 1'b0, 1'b0, a);
    async_reset();
    step(1'b1, 8'h5A, 1'b1, 1'b0, a);
    chk("post_reset_S3_not_yet", ov3, 1'b0);
    idle(4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0, a);
    idle(5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
